// File: rtl/apb_slave_responder.sv
// APB slave with a small byte-strobed register memory and programmable wait states.
// Optional macro APB_SLAVE_PROT_CHECK_EN rejects unprivileged writes (pprot[0]=0) with pslverr.
module apb_slave_responder #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int          MEM_DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                wait_states,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [ADDRESS_WIDTH:0]   SPAN = (ADDRESS_WIDTH + 1)'(4 * MEM_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

  logic [1:0]              state;
  logic [3:0]              cnt;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [IDX_W-1:0]        idx_p0;
  logic                    wr_p0;
  logic                    err_p0;
  logic [DATA_WIDTH-1:0]   wdata_p0;
  logic [STRB_W-1:0]       strb_p0;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         idx_in;
  logic                     addr_err;
  logic                     prot_err;
  logic                     req_err;
  logic                     setup;

  assign offset   = paddr - BASE;
  assign idx_in   = offset[IDX_W+1:2];
  assign addr_err = (paddr < BASE) || ({1'b0, offset} >= SPAN) || (paddr[1:0] != 2'b00);

`ifdef APB_SLAVE_PROT_CHECK_EN
  logic unused_prot;
  assign prot_err    = pwrite & ~pprot[0];
  assign unused_prot = ^pprot[2:1];
`else
  logic unused_prot;
  assign prot_err    = 1'b0;
  assign unused_prot = ^pprot;
`endif

  assign req_err = addr_err | prot_err;
  assign setup   = (state == IDLE) && psel && !penable;
  assign pready  = (state == READY);

  // request capture: setup-phase fields held for the rest of the transfer
  always_ff @(posedge pclk) begin
    if (setup) begin
      idx_p0   <= idx_in;
      wr_p0    <= pwrite;
      wdata_p0 <= pwdata;
      strb_p0  <= pstrb;
      err_p0   <= req_err;
    end
  end

  // control: FSM, wait counter, response registers and storage
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      prdata  <= '0;
      pslverr <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            if (wait_states == 4'd0) begin
              state   <= READY;
              prdata  <= (!pwrite && !req_err) ? mem[idx_in] : '0;
              pslverr <= req_err;
            end else begin
              state <= WAIT;
              cnt   <= wait_states;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (!psel) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state   <= READY;
            prdata  <= (!wr_p0 && !err_p0) ? mem[idx_p0] : '0;
            pslverr <= err_p0;
          end
        end
        READY: begin
          // psel low aborts; psel with penable completes; psel without penable holds
          if (!psel || penable) begin
            state   <= IDLE;
            prdata  <= '0;
            pslverr <= 1'b0;
            if (psel && wr_p0 && !err_p0)
              mem[idx_p0] <= merge_bytes(mem[idx_p0], wdata_p0, strb_p0);
          end
        end
        default: begin
          state   <= IDLE;
          prdata  <= '0;
          pslverr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_slave_responder.md
APB_SLAVE_RESPONDER -- requirements
Module: apb_slave_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, pwdata/prdata width; pstrb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_DEPTH, default 16, number of DATA_WIDTH-bit storage words.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-005 SHALL have ports:
- pclk  in  1  clock; all state updates on the rising edge.
- preset_n  in  1  reset; asynchronous, active-low.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDRESS_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- pprot  in  3  protection type.
- wait_states  in  4  wait cycles to insert before pready, 0-15.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data.
- pslverr  out  1  transfer error.

Function
REQ-006 SHALL implement FSM IDLE, WAIT, READY; pready is 1 only in READY.
REQ-007 IDLE: on psel=1 and penable=0 (setup phase), SHALL latch paddr, pwrite, pwdata, pstrb, pprot and error status.
REQ-008 IDLE setup transitions: if wait_states=0, go to READY; otherwise load counter with wait_states and go to WAIT.
REQ-009 WAIT: counter SHALL decrement each cycle; the transition to READY occurs on the edge where the counter equals 1. pready therefore rises exactly wait_states cycles after the first access cycle.
REQ-010 Completion: the edge with psel=1, penable=1, pready=1 SHALL complete the transfer, perform any write, and return the FSM to IDLE. A setup phase in the next cycle (back-to-back transfer) SHALL be accepted.
REQ-011 Abort: if psel=0 in WAIT or READY, SHALL return to IDLE with no memory write and pready=0.
REQ-012 Word index SHALL be (paddr-BASE_ADDR)>>2.
- Error when paddr<BASE_ADDR, paddr>=BASE_ADDR+4*MEM_DEPTH, or paddr[1:0]!=0.
REQ-013 Write without error: for each i with pstrb[i]=1, SHALL update byte lane i of the addressed word. pstrb=0 leaves the word unchanged and is not an error.
REQ-014 Read without error: prdata SHALL present the addressed word, registered on entry to READY and held while in READY; pstrb is ignored.
REQ-015 pslverr SHALL be 1 only in READY for errored transfers; an errored write SHALL not modify memory, and an errored read SHALL drive prdata=0.
REQ-016 Outside READY, prdata and pslverr SHALL be 0.
REQ-017 A wait_states change after setup SHALL not affect the transfer in progress.

Reset
REQ-018 While preset_n=0, SHALL asynchronously force FSM=IDLE, counter=0, pready=0, prdata=0, pslverr=0, and all memory words=0.
REQ-019 Reset asserted mid-transfer SHALL abandon the transfer with no write. The first setup phase after deassertion SHALL be handled normally.

Configuration
REQ-020 Macro APB_SLAVE_PROT_CHECK_EN:
- Defined: a write with pprot[0]=0 (normal, unprivileged access) SHALL complete with pslverr=1 and no memory change; reads are unaffected.
- Undefined: pprot SHALL be ignored entirely.

Verification
REQ-021 Write 0xDEADBEEF to 0x04 with pstrb=4'hF and wait_states=0, then read 0x04 -> pready is high in the first access cycle, prdata=0xDEADBEEF, pslverr=0.
REQ-022 wait_states=3, read 0x00 after reset -> pready rises on the 4th access cycle, prdata=0x0.
REQ-023 Word 0x08 holds 0x11223344; write 0xAABBCCDD with pstrb=4'b0101 -> reading 0x08 returns 0x11BB33DD.
REQ-024 Write to 0x40 (MEM_DEPTH=16) and write to 0x06 -> both complete with pslverr=1 and memory unchanged; read of 0x40 returns prdata=0, pslverr=1.
REQ-025 Assert preset_n=0 during WAIT of a write to 0x0C -> pready=0 immediately and word 0x0C remains 0; the following transfer completes normally.
REQ-026 With APB_SLAVE_PROT_CHECK_EN defined, write 0x55 to 0x10 with pprot=3'b000 -> pslverr=1 and read returns 0. Repeating with pprot=3'b001 -> pslverr=0 and read returns 0x55.
